tx_frame_logic: RTL and testbench

Transmit-side gPTP frame builder. It accepts one message request at a time from the gPTP protocol engine (message type, timestamps, sequence id) and encodes a fixed 432-bit (54-byte) gPTP PDU. It hands the PDU to the transmit FIFO over a valid/ready handshake and reports completion with the sequence id actually used. It owns the Sync and Pdelay_Req sequence-id counters.

---
 rtl/tx_frame_logic.sv | 180 ++++++++++++++++++
 tb/tb_tx_frame_logic.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_logic.sv
// gPTP transmit frame builder: latches one request, encodes a 54-byte PDU, hands it over valid/ready.
// Request to PDU valid is 2 cycles; the PDU is held until accepted, and new requests are refused until then.
module tx_frame_logic #(
    parameter logic [63:0] CLOCK_ID            = 64'h0,
    parameter logic [15:0] PORT_NUM            = 16'd1,
    parameter logic [7:0]  DOMAIN              = 8'd0,
    parameter logic [7:0]  LOG_SYNC_INTERVAL   = 8'hFD,
    parameter logic [7:0]  LOG_PDELAY_INTERVAL = 8'h00
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tx_req_vaild,
    output logic         tx_req_ready,
    input  logic [7:0]   tx_req_type,
    input  logic [15:0]  tx_req_seq,
    input  logic [79:0]  tx_req_data1,
    input  logic [79:0]  tx_req_data2,
    output logic [431:0] gptp_tx_data,
    output logic         gptp_tx_vaild,
    input  logic         gptp_tx_ready,
    output logic         tx_done,
    output logic [7:0]   tx_done_type,
    output logic [15:0]  tx_done_seq,
    output logic         tx_err
);

    localparam logic [7:0] T_SYNC  = 8'h00;
    localparam logic [7:0] T_PREQ  = 8'h02;
    localparam logic [7:0] T_PRESP = 8'h03;
    localparam logic [7:0] T_FUP   = 8'h08;
    localparam logic [7:0] T_PRFUP = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    logic [7:0]   r_type;
    logic [15:0]  r_seq;
    logic [79:0]  r_data1;
    logic [79:0]  r_data2;
    logic [15:0]  r_sync_cnt;
    logic [15:0]  r_preq_cnt;
    logic [15:0]  r_last_sync_seq;

    logic         w_supported;
    logic [15:0]  w_len;
    logic [15:0]  w_flags;
    logic [7:0]   w_ctrl;
    logic [7:0]   w_logint;
    logic [15:0]  w_seq;
    logic [79:0]  w_body1;
    logic [79:0]  w_body2;
    logic [431:0] w_pdu;

    // Field selection works from the latched request, so the PDU is stable through ENC.
    always_comb begin
        w_supported = 1'b0;
        w_len       = 16'd54;
        w_flags     = 16'h0000;
        w_ctrl      = 8'h05;
        w_logint    = 8'h7F;
        w_seq       = r_seq;
        w_body1     = 80'h0;
        w_body2     = 80'h0;
        case (r_type)
            T_SYNC: begin
                w_supported = 1'b1;
                w_len       = 16'd44;
                w_flags     = 16'h0200;
                w_ctrl      = 8'h00;
                w_logint    = LOG_SYNC_INTERVAL;
                w_seq       = r_sync_cnt;
            end
            T_PREQ: begin
                w_supported = 1'b1;
                w_logint    = LOG_PDELAY_INTERVAL;
                w_seq       = r_preq_cnt;
            end
            T_PRESP: begin
                w_supported = 1'b1;
                w_flags     = 16'h0200;
                w_body1     = r_data1;
                w_body2     = r_data2;
            end
            T_FUP: begin
                w_supported = 1'b1;
                w_len       = 16'd76;
                w_ctrl      = 8'h02;
                w_logint    = LOG_SYNC_INTERVAL;
                w_seq       = r_last_sync_seq;
                w_body1     = r_data1;
            end
            T_PRFUP: begin
                w_supported = 1'b1;
                w_body1     = r_data1;
                w_body2     = r_data2;
            end
            default: begin
                w_supported = 1'b0;
            end
        endcase

        w_pdu = {4'h1, r_type[3:0], 8'h02, w_len, DOMAIN, 8'h00, w_flags,
                 96'h0, CLOCK_ID, PORT_NUM, w_seq, w_ctrl, w_logint,
                 w_body1, w_body2};
    end

    assign tx_req_ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_type          <= 8'h0;
            r_seq           <= 16'h0;
            r_data1         <= 80'h0;
            r_data2         <= 80'h0;
            r_sync_cnt      <= 16'h0;
            r_preq_cnt      <= 16'h0;
            r_last_sync_seq <= 16'h0;
            gptp_tx_data    <= 432'h0;
            gptp_tx_vaild   <= 1'b0;
            tx_done         <= 1'b0;
            tx_done_type    <= 8'h0;
            tx_done_seq     <= 16'h0;
            tx_err          <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (tx_req_vaild) begin
                        r_type  <= tx_req_type;
                        r_seq   <= tx_req_seq;
                        r_data1 <= tx_req_data1;
                        r_data2 <= tx_req_data2;
                        r_state <= S_ENC;
                    end
                end
                S_ENC: begin
                    if (w_supported) begin
                        gptp_tx_data  <= w_pdu;
                        gptp_tx_vaild <= 1'b1;
                        r_state       <= S_SEND;
                    end else begin
                        tx_err  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_SEND: begin
                    if (gptp_tx_ready) begin
                        gptp_tx_vaild <= 1'b0;
                        tx_done       <= 1'b1;
                        tx_done_type  <= r_type;
                        // Report the sequenceId that actually went out in bytes 30-31.
                        tx_done_seq   <= gptp_tx_data[191:176];
                        if (r_type == T_SYNC) begin
                            r_last_sync_seq <= r_sync_cnt;
                            r_sync_cnt      <= r_sync_cnt + 16'd1;
                        end
                        if (r_type == T_PREQ) begin
                            r_preq_cnt <= r_preq_cnt + 16'd1;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_logic.sv
// Directed bench for tx_frame_logic: hand-computed PDU fields, latencies, counters and reset.
module tb_tx_frame_logic;

    logic         clk;
    logic         reset;
    logic         tx_req_vaild;
    logic         tx_req_ready;
    logic [7:0]   tx_req_type;
    logic [15:0]  tx_req_seq;
    logic [79:0]  tx_req_data1;
    logic [79:0]  tx_req_data2;
    logic [431:0] gptp_tx_data;
    logic         gptp_tx_vaild;
    logic         gptp_tx_ready;
    logic         tx_done;
    logic [7:0]   tx_done_type;
    logic [15:0]  tx_done_seq;
    logic         tx_err;

    int total = 0;
    int bad   = 0;

    localparam logic [79:0] D1_FUP = 80'h000000000001_0000000A;
    localparam logic [79:0] D1_PR  = 80'h0000_1234_5678_9ABC_DEF0;
    localparam logic [79:0] D2_PR  = 80'h0011223344556677_0002;
    localparam logic [79:0] D_JUNK = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

    tx_frame_logic dut (
        .clk           (clk),
        .reset         (reset),
        .tx_req_vaild  (tx_req_vaild),
        .tx_req_ready  (tx_req_ready),
        .tx_req_type   (tx_req_type),
        .tx_req_seq    (tx_req_seq),
        .tx_req_data1  (tx_req_data1),
        .tx_req_data2  (tx_req_data2),
        .gptp_tx_data  (gptp_tx_data),
        .gptp_tx_vaild (gptp_tx_vaild),
        .gptp_tx_ready (gptp_tx_ready),
        .tx_done       (tx_done),
        .tx_done_type  (tx_done_type),
        .tx_done_seq   (tx_done_seq),
        .tx_err        (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [431:0] obs, input logic [431:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Sync PDU with default parameters, written out field by field.
    function automatic logic [431:0] sync_pdu(input logic [15:0] seq);
        return {8'h10, 8'h02, 16'd44, 8'h00, 8'h00, 16'h0200, 96'h0, 64'h0,
                16'h0001, seq, 8'h00, 8'hFD, 160'h0};
    endfunction

    function automatic logic [7:0] byte_at(input logic [431:0] p, input int idx);
        return p[431 - 8*idx -: 8];
    endfunction

    function automatic logic [15:0] half_at(input logic [431:0] p, input int idx);
        return {byte_at(p, idx), byte_at(p, idx + 1)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Present a request for exactly one edge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [7:0] t, input logic [15:0] s,
                         input logic [79:0] d1, input logic [79:0] d2);
        tx_req_type  = t;
        tx_req_seq   = s;
        tx_req_data1 = d1;
        tx_req_data2 = d2;
        tx_req_vaild = 1'b1;
        @(negedge clk);
        tx_req_vaild = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        tx_req_vaild  = 1'b0;
        tx_req_type   = 8'h0;
        tx_req_seq    = 16'h0;
        tx_req_data1  = 80'h0;
        tx_req_data2  = 80'h0;
        gptp_tx_ready = 1'b0;

        repeat (3) step();
        chk("rst_vaild", gptp_tx_vaild, 0);
        chk("rst_done",  tx_done, 0);
        chk("rst_err",   tx_err, 0);
        chk("rst_data",  gptp_tx_data, 0);
        chk("rst_dtype", tx_done_type, 0);
        chk("rst_dseq",  tx_done_seq, 0);
        reset = 1'b1;
        step();
        chk("rst_ready", tx_req_ready, 1);
        chk("rst_scnt",  dut.r_sync_cnt, 0);
        chk("rst_pcnt",  dut.r_preq_cnt, 0);

        // Sync with the FIFO always ready.
        gptp_tx_ready = 1'b1;
        issue(8'h00, 16'hBEEF, D_JUNK, D_JUNK);
        chk("sync_lat1_vaild", gptp_tx_vaild, 0);
        chk("sync_busy_ready", tx_req_ready, 0);
        step();
        chk("sync_vaild", gptp_tx_vaild, 1);
        chk("sync_pdu",   gptp_tx_data, sync_pdu(16'h0000));
        chk("sync_byte0", byte_at(gptp_tx_data, 0), 8'h10);
        chk("sync_len",   half_at(gptp_tx_data, 2), 16'd44);
        chk("sync_flags", half_at(gptp_tx_data, 6), 16'h0200);
        chk("sync_b33",   byte_at(gptp_tx_data, 33), 8'hFD);
        step();
        chk("sync_vaild_drop", gptp_tx_vaild, 0);
        chk("sync_done",  tx_done, 1);
        chk("sync_dtype", tx_done_type, 8'h00);
        chk("sync_dseq",  tx_done_seq, 16'h0000);
        chk("sync_scnt",  dut.r_sync_cnt, 16'd1);
        step();
        chk("sync_done_clr", tx_done, 0);
        chk("sync_ready",    tx_req_ready, 1);

        // Follow_Up reuses the last completed Sync's sequenceId.
        issue(8'h08, 16'h5555, D1_FUP, D_JUNK);
        step();
        chk("fup_vaild", gptp_tx_vaild, 1);
        chk("fup_byte0", byte_at(gptp_tx_data, 0), 8'h18);
        chk("fup_seq",   half_at(gptp_tx_data, 30), 16'h0000);
        chk("fup_len",   half_at(gptp_tx_data, 2), 16'd76);
        chk("fup_flags", half_at(gptp_tx_data, 6), 16'h0000);
        chk("fup_ctrl",  byte_at(gptp_tx_data, 32), 8'h02);
        chk("fup_b33",   byte_at(gptp_tx_data, 33), 8'hFD);
        chk("fup_body1", gptp_tx_data[159:80], D1_FUP);
        chk("fup_body2", gptp_tx_data[79:0], 0);
        step();
        chk("fup_dtype", tx_done_type, 8'h08);
        chk("fup_dseq",  tx_done_seq, 16'h0000);
        chk("fup_scnt",  dut.r_sync_cnt, 16'd1);
        step();

        // Pdelay_Resp carries the caller's sequenceId and both body fields.
        issue(8'h03, 16'h1234, D1_PR, D2_PR);
        step();
        chk("presp_byte0", byte_at(gptp_tx_data, 0), 8'h13);
        chk("presp_seq",   half_at(gptp_tx_data, 30), 16'h1234);
        chk("presp_len",   half_at(gptp_tx_data, 2), 16'd54);
        chk("presp_flags", half_at(gptp_tx_data, 6), 16'h0200);
        chk("presp_ctrl",  byte_at(gptp_tx_data, 32), 8'h05);
        chk("presp_b33",   byte_at(gptp_tx_data, 33), 8'h7F);
        chk("presp_pid",   half_at(gptp_tx_data, 28), 16'h0001);
        chk("presp_body1", gptp_tx_data[159:80], D1_PR);
        chk("presp_body2", gptp_tx_data[79:0], D2_PR);
        step();
        chk("presp_dseq", tx_done_seq, 16'h1234);
        chk("presp_pcnt", dut.r_preq_cnt, 16'd0);
        chk("presp_scnt", dut.r_sync_cnt, 16'd1);
        step();

        // Backpressure: FIFO stalls for 10 cycles on a Sync (seq 1).
        gptp_tx_ready = 1'b0;
        issue(8'h00, 16'h0, 80'h0, 80'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("stall_vaild", gptp_tx_vaild, 1);
            chk("stall_pdu",   gptp_tx_data, sync_pdu(16'h0001));
            chk("stall_ready", tx_req_ready, 0);
            chk("stall_done",  tx_done, 0);
            step();
        end
        gptp_tx_ready = 1'b1;
        step();
        chk("stall_vaild_drop", gptp_tx_vaild, 0);
        chk("stall_done_p",     tx_done, 1);
        chk("stall_dseq",       tx_done_seq, 16'h0001);
        chk("stall_last",       dut.r_last_sync_seq, 16'h0001);
        chk("stall_scnt",       dut.r_sync_cnt, 16'd2);
        step();

        // Pdelay_Req counter wrap.
        force dut.r_preq_cnt = 16'hFFFF;
        step();
        release dut.r_preq_cnt;
        issue(8'h02, 16'h7777, D_JUNK, D_JUNK);
        step();
        chk("preq0_seq",   half_at(gptp_tx_data, 30), 16'hFFFF);
        chk("preq0_b33",   byte_at(gptp_tx_data, 33), 8'h00);
        chk("preq0_ctrl",  byte_at(gptp_tx_data, 32), 8'h05);
        chk("preq0_flags", half_at(gptp_tx_data, 6), 16'h0000);
        chk("preq0_body",  gptp_tx_data[159:0], 0);
        step();
        chk("preq0_dseq", tx_done_seq, 16'hFFFF);
        chk("preq0_pcnt", dut.r_preq_cnt, 16'h0000);
        step();
        issue(8'h02, 16'h7777, D_JUNK, D_JUNK);
        step();
        chk("preq1_seq", half_at(gptp_tx_data, 30), 16'h0000);
        step();
        chk("preq1_dseq", tx_done_seq, 16'h0000);
        chk("preq1_pcnt", dut.r_preq_cnt, 16'h0001);
        step();

        // Unsupported type.
        issue(8'h05, 16'h0, D_JUNK, D_JUNK);
        chk("err_lat1", tx_err, 0);
        step();
        chk("err_pulse", tx_err, 1);
        chk("err_vaild", gptp_tx_vaild, 0);
        chk("err_ready", tx_req_ready, 1);
        step();
        chk("err_clr",  tx_err, 0);
        chk("err_done", tx_done, 0);
        chk("err_scnt", dut.r_sync_cnt, 16'd2);
        chk("err_pcnt", dut.r_preq_cnt, 16'd1);

        // Reset while a PDU waits in SEND.
        gptp_tx_ready = 1'b0;
        issue(8'h00, 16'h0, 80'h0, 80'h0);
        step();
        chk("rsend_vaild", gptp_tx_vaild, 1);
        reset = 1'b0;
        step();
        chk("rsend_vaild_clr", gptp_tx_vaild, 0);
        chk("rsend_data",      gptp_tx_data, 0);
        chk("rsend_scnt",      dut.r_sync_cnt, 0);
        chk("rsend_pcnt",      dut.r_preq_cnt, 0);
        chk("rsend_last",      dut.r_last_sync_seq, 0);
        chk("rsend_ready",     tx_req_ready, 1);
        reset = 1'b1;

        // Ready with nothing pending does nothing.
        gptp_tx_ready = 1'b1;
        step();
        step();
        chk("idle_rdy_done", tx_done, 0);

        // After reset the Sync counter restarts; one cycle of valid with ready held.
        issue(8'h00, 16'h0, 80'h0, 80'h0);
        step();
        chk("post_pdu", gptp_tx_data, sync_pdu(16'h0000));
        step();
        chk("post_vaild_1cyc", gptp_tx_vaild, 0);
        chk("post_dseq",       tx_done_seq, 16'h0000);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
